axis_block_detector: RTL and testbench

AXIS_BLOCK_DETECTOR -- requirements
Module: axis_block_detector

---
 rtl/axis_block_detector_pkg.sv | 23 ++
 rtl/axis_stall_fsm.sv | 74 +++++++
 rtl/axis_block_detector.sv | 96 +++++++++
 tb/tb_axis_block_detector.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/axis_block_detector_pkg.sv
// Shared types and defaults for the AXI-Stream block detector.
// Holds the per-channel FSM state encoding and the stall-condition helper.
package axis_block_detector_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StStall   = 2'd1,
    StBlocked = 2'd2
  } stall_state_e;

  localparam int unsigned DefaultStallThresh = 16;

  // dir=0: the DUT reads, so a stall means the DUT is ready and nothing arrives.
  // dir=1: the DUT writes, so a stall means data is offered and nobody takes it.
  function automatic logic stall_cond(input logic dir, input logic enable,
                                      input logic tvalid, input logic tready);
    if (dir) begin
      return enable & tvalid & ~tready;
    end
    return enable & tready & ~tvalid;
  endfunction

endpackage

// File: rtl/axis_stall_fsm.sv
// Single-channel stall tracker: IDLE -> STALL -> BLOCKED with an 8-bit
// consecutive-stall counter.
module axis_stall_fsm
  import axis_block_detector_pkg::*;
#(
  parameter int unsigned STALL_THRESH = DefaultStallThresh
) (
  input  logic clock,
  input  logic reset,
  input  logic enable_i,
  input  logic stall_i,
  output logic blocked_o,
  output logic enter_o
);

  localparam logic [7:0] ThreshM1 = 8'(STALL_THRESH - 1);

  stall_state_e state_q, state_d;
  logic [7:0]   count_q, count_d;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (!enable_i) begin
      state_d = StIdle;
      count_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (stall_i) begin
            state_d = StStall;
            count_d = 8'd1;
          end
        end
        StStall: begin
          if (!stall_i) begin
            state_d = StIdle;
            count_d = '0;
          end else if (count_q == ThreshM1) begin
            state_d = StBlocked;
            count_d = count_q + 8'd1;
          end else begin
            count_d = count_q + 8'd1;
          end
        end
        StBlocked: begin
          if (!stall_i) begin
            state_d = StIdle;
            count_d = '0;
          end
        end
        default: begin
          state_d = StIdle;
          count_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign blocked_o = (state_q == StBlocked);
  // High on the edge that moves this channel into BLOCKED.
  assign enter_o   = (state_d == StBlocked) && (state_q != StBlocked);

endmodule

// File: rtl/axis_block_detector.sv
// Per-channel AXI-Stream blocking detector with first-blocker capture and a
// saturating count of cycles spent with any channel blocked.
module axis_block_detector
  import axis_block_detector_pkg::*;
#(
  parameter int unsigned            NUM_CH       = 4,
  parameter int unsigned            STALL_THRESH = DefaultStallThresh,
  parameter logic [NUM_CH-1:0]      CH_DIR       = 4'b1100,
  localparam int unsigned           IdxW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic [NUM_CH-1:0] tvalid,
  input  logic [NUM_CH-1:0] tready,
  output logic [NUM_CH-1:0] axis_block_sigs,
  output logic              any_block,
  output logic [IdxW-1:0]   first_block_idx,
  output logic              first_valid,
  output logic [15:0]       stall_cycles
);

  logic [NUM_CH-1:0] stall;
  logic [NUM_CH-1:0] blocked;
  logic [NUM_CH-1:0] enter;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign stall[i] = stall_cond(CH_DIR[i], enable, tvalid[i], tready[i]);

    axis_stall_fsm #(
      .STALL_THRESH(STALL_THRESH)
    ) u_fsm (
      .clock    (clock),
      .reset    (reset),
      .enable_i (enable),
      .stall_i  (stall[i]),
      .blocked_o(blocked[i]),
      .enter_o  (enter[i])
    );
  end

  assign axis_block_sigs = blocked;
  assign any_block       = |blocked;

  // Lowest-index channel entering BLOCKED this cycle.
  logic [IdxW-1:0] enter_idx;
  always_comb begin
    enter_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (enter[i]) begin
        enter_idx = IdxW'(i);
      end
    end
  end

  logic            first_valid_q, first_valid_d;
  logic [IdxW-1:0] first_idx_q, first_idx_d;
  logic [15:0]     stall_cycles_q, stall_cycles_d;

  always_comb begin
    first_valid_d  = first_valid_q;
    first_idx_d    = first_idx_q;
    stall_cycles_d = stall_cycles_q;
    if (clear) begin
      first_valid_d  = 1'b0;
      first_idx_d    = '0;
      stall_cycles_d = '0;
    end else begin
      if (!first_valid_q && (|enter)) begin
        first_valid_d = 1'b1;
        first_idx_d   = enter_idx;
      end
      if (any_block && (stall_cycles_q != 16'hFFFF)) begin
        stall_cycles_d = stall_cycles_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      first_valid_q  <= 1'b0;
      first_idx_q    <= '0;
      stall_cycles_q <= '0;
    end else begin
      first_valid_q  <= first_valid_d;
      first_idx_q    <= first_idx_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign first_valid     = first_valid_q;
  assign first_block_idx = first_idx_q;
  assign stall_cycles    = stall_cycles_q;

endmodule

// File: tb/tb_axis_block_detector.sv
// Directed, table-driven bench for axis_block_detector with default parameters
// (4 channels, threshold 16, ch0/ch1 read, ch2/ch3 write).
module tb_axis_block_detector;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        clear;
  logic [3:0]  tvalid;
  logic [3:0]  tready;
  logic [3:0]  axis_block_sigs;
  logic        any_block;
  logic [1:0]  first_block_idx;
  logic        first_valid;
  logic [15:0] stall_cycles;

  int n_checks = 0;
  int n_pass   = 0;

  axis_block_detector dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .clear          (clear),
    .tvalid         (tvalid),
    .tready         (tready),
    .axis_block_sigs(axis_block_sigs),
    .any_block      (any_block),
    .first_block_idx(first_block_idx),
    .first_valid    (first_valid),
    .stall_cycles   (stall_cycles)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        en;
    logic        clr;
    logic [3:0]  tv;
    logic [3:0]  tr;
    int          cycles;
    logic [3:0]  exp_blk;
    logic        exp_fv;
    logic [1:0]  exp_idx;
    logic [15:0] exp_sc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic en, input logic clr, input logic [3:0] tv,
                     input logic [3:0] tr, input int cycles, input logic [3:0] blk,
                     input logic fv, input logic [1:0] idx, input logic [15:0] sc);
    vec_t v;
    v.en = en; v.clr = clr; v.tv = tv; v.tr = tr; v.cycles = cycles;
    v.exp_blk = blk; v.exp_fv = fv; v.exp_idx = idx; v.exp_sc = sc;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [3:0] blk, input logic fv,
                           input logic [1:0] idx, input logic [15:0] sc);
    check({tag, ".blk"}, 32'(axis_block_sigs), 32'(blk));
    check({tag, ".any"}, 32'(any_block), 32'(|blk));
    check({tag, ".fv"},  32'(first_valid), 32'(fv));
    check({tag, ".idx"}, 32'(first_block_idx), 32'(idx));
    check({tag, ".sc"},  32'(stall_cycles), 32'(sc));
  endtask

  initial begin
    // ch0 read stall: tr=0001 tv=0000. ch2 write stall: tv=0100 tr=0000.
    // ch1 read + ch3 write: tv=1000 tr=0010.
    add(1, 0, 4'b0000, 4'b0001, 15, 4'b0000, 0, 0, 0);
    add(1, 0, 4'b0000, 4'b0001,  1, 4'b0001, 1, 0, 0);
    add(1, 0, 4'b0000, 4'b0001,  3, 4'b0001, 1, 0, 3);
    add(0, 0, 4'b0000, 4'b0001,  1, 4'b0000, 1, 0, 4);
    add(0, 0, 4'b0000, 4'b0001,  2, 4'b0000, 1, 0, 4);
    add(1, 1, 4'b0000, 4'b0000,  1, 4'b0000, 0, 0, 0);
    add(1, 0, 4'b0100, 4'b0000, 15, 4'b0000, 0, 0, 0);
    add(1, 0, 4'b0100, 4'b0100,  1, 4'b0000, 0, 0, 0);
    add(1, 0, 4'b0100, 4'b0000, 15, 4'b0000, 0, 0, 0);
    add(1, 0, 4'b0100, 4'b0000,  1, 4'b0100, 1, 2, 0);
    add(1, 0, 4'b0000, 4'b0000,  1, 4'b0000, 1, 2, 1);
    add(1, 1, 4'b0000, 4'b0000,  1, 4'b0000, 0, 0, 0);
    add(1, 0, 4'b1000, 4'b0010, 15, 4'b0000, 0, 0, 0);
    add(1, 0, 4'b1000, 4'b0010,  1, 4'b1010, 1, 1, 0);
    add(1, 0, 4'b1000, 4'b0010,  4, 4'b1010, 1, 1, 4);
    add(1, 0, 4'b0000, 4'b0000,  1, 4'b0000, 1, 1, 5);
    add(1, 0, 4'b1000, 4'b0000, 16, 4'b1000, 1, 1, 5);
    add(1, 0, 4'b1000, 4'b0000,  2, 4'b1000, 1, 1, 7);
    add(1, 1, 4'b1000, 4'b0000,  1, 4'b1000, 0, 0, 0);
    add(1, 0, 4'b1000, 4'b0000,  1, 4'b1000, 0, 0, 1);
    add(1, 0, 4'b1000, 4'b0000,  2, 4'b1000, 0, 0, 3);
    add(1, 0, 4'b0000, 4'b0000,  1, 4'b0000, 0, 0, 4);
    add(1, 0, 4'b0000, 4'b0001, 16, 4'b0001, 1, 0, 4);
    add(1, 0, 4'b0000, 4'b0000,  1, 4'b0000, 1, 0, 5);
    add(1, 1, 4'b0000, 4'b0000,  1, 4'b0000, 0, 0, 0);
    add(1, 0, 4'b0100, 4'b0000, 15, 4'b0000, 0, 0, 0);
    // Clear on the same edge as a BLOCKED entry: clear wins, no capture.
    add(1, 1, 4'b0100, 4'b0000,  1, 4'b0100, 0, 0, 0);
    add(1, 0, 4'b0100, 4'b0000,  1, 4'b0100, 0, 0, 1);

    reset  = 1'b1;
    enable = 1'b1;
    clear  = 1'b1;
    tvalid = 4'b1111;
    tready = 4'b0000;
    step(2);
    check_all("reset", 4'b0000, 0, 0, 0);
    reset  = 1'b0;
    clear  = 1'b0;
    tvalid = 4'b0000;

    for (int i = 0; i < vecs.size(); i++) begin
      enable = vecs[i].en;
      clear  = vecs[i].clr;
      tvalid = vecs[i].tv;
      tready = vecs[i].tr;
      step(vecs[i].cycles);
      check_all($sformatf("vec%0d", i), vecs[i].exp_blk, vecs[i].exp_fv,
                vecs[i].exp_idx, vecs[i].exp_sc);
    end

    // Reset mid-stall: ch2 still blocked, ch0 at stall cycle 10.
    enable = 1'b1;
    clear  = 1'b0;
    tvalid = 4'b0100;
    tready = 4'b0001;
    step(10);
    check_all("pre_rst", 4'b0100, 0, 0, 11);
    reset = 1'b1;
    step(1);
    check_all("mid_rst", 4'b0000, 0, 0, 0);
    reset = 1'b0;
    step(15);
    check_all("post_rst15", 4'b0000, 0, 0, 0);
    // ch0 and ch2 enter BLOCKED together: lowest index wins.
    step(1);
    check_all("post_rst16", 4'b0101, 1, 0, 0);
    step(1);
    check_all("post_rst17", 4'b0101, 1, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
